// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared HWPE-Stream types
package hwpe_stream_package;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_linsrc_t;

endpackage

// File: rtl/hwpe_stream_fifo.sv
// rtl/hwpe_stream_fifo.sv - power-of-two word FIFO with registered storage
module hwpe_stream_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  logic                          push_valid_i,
   input  logic [DATA_WIDTH-1:0]         push_data_i,
   output logic                          pop_valid_o,
   output logic [DATA_WIDTH-1:0]         pop_data_o,
   input  logic                          pop_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   used_o
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           used_q;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                  full, do_push, do_pop;

   assign full        = (used_q == (AW+1)'(FIFO_DEPTH));
   assign pop_valid_o = (used_q != '0);
   assign pop_data_o  = mem_q[rd_ptr_q];
   assign used_o      = used_q;
   assign do_pop      = pop_valid_o & pop_ready_i;
   // A push into a full FIFO is accepted only when the head leaves in the same cycle
   assign do_push     = push_valid_i & (~full | do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      used_q <= used_q + 1'b1;
         else if (!do_push && do_pop) used_q <= used_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/hwpe_stream_source_linear.sv
// rtl/hwpe_stream_source_linear.sv - strided TCDM reader feeding an HWPE-Stream
module hwpe_stream_source_linear
   import hwpe_stream_package::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [31:0]          base_addr_i,
   input  logic [31:0]          stride_i,
   input  logic [CNT_WIDTH-1:0] count_i,
   output logic                 ready_start_o,
   output logic                 done_o,
   output logic                 tcdm_req_o,
   input  logic                 tcdm_gnt_i,
   output logic [31:0]          tcdm_add_o,
   output logic                 tcdm_wen_o,
   output logic [3:0]           tcdm_be_o,
   output logic [31:0]          tcdm_data_o,
   input  logic [31:0]          tcdm_r_data_i,
   input  logic                 tcdm_r_valid_i,
   output logic                 valid_o,
   output logic [31:0]          data_o,
   output logic [3:0]           strb_o,
   input  logic                 ready_i
);
   localparam int unsigned UW = $clog2(FIFO_DEPTH) + 1;

   state_linsrc_t        cs_q, cs_d;
   logic [31:0]          addr_q, stride_q;
   logic [CNT_WIDTH-1:0] issue_left_q, pop_left_q;
   logic                 inflight_q, drop_q, done_q;
   logic [UW-1:0]        fifo_used;
   logic [UW:0]          credit;
   logic                 granted, pop, push, last_pop;

   // Credit covers buffered words plus the one response that may still be in flight
   assign credit     = {1'b0, fifo_used} + {{UW{1'b0}}, inflight_q};
   assign tcdm_req_o = (cs_q == ISSUE) && (issue_left_q != '0)
                       && (credit < (UW+1)'(FIFO_DEPTH));
   assign granted    = tcdm_req_o & tcdm_gnt_i;
   assign pop        = valid_o & ready_i;
   assign push       = tcdm_r_valid_i & ~drop_q;
   assign last_pop   = pop && (pop_left_q == CNT_WIDTH'(1));

   assign ready_start_o = (cs_q == IDLE);
   assign done_o        = done_q;
   assign tcdm_add_o    = addr_q;
   assign tcdm_wen_o    = 1'b1;
   assign tcdm_be_o     = 4'hF;
   assign tcdm_data_o   = 32'h0;
   assign strb_o        = 4'hF;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cs_q <= IDLE;
      else         cs_q <= cs_d;
   end

   always_comb begin
      cs_d = cs_q;
      case (cs_q)
         IDLE:    if (start_i && count_i != '0) cs_d = ISSUE;
         ISSUE:   if (granted && issue_left_q == CNT_WIDTH'(1)) cs_d = DRAIN;
         DRAIN:   if (last_pop) cs_d = IDLE;
         default: cs_d = IDLE;
      endcase
      if (clear_i) cs_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q       <= '0;
         stride_q     <= '0;
         issue_left_q <= '0;
         pop_left_q   <= '0;
         inflight_q   <= 1'b0;
         drop_q       <= 1'b0;
         done_q       <= 1'b0;
      end else if (clear_i) begin
         addr_q       <= '0;
         stride_q     <= '0;
         issue_left_q <= '0;
         pop_left_q   <= '0;
         inflight_q   <= 1'b0;
         drop_q       <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         inflight_q <= granted;
         drop_q     <= 1'b0;
         done_q     <= ((cs_q == IDLE) && start_i && count_i == '0)
                       || ((cs_q == DRAIN) && last_pop);
         if (cs_q == IDLE && start_i) begin
            addr_q       <= base_addr_i;
            stride_q     <= stride_i;
            issue_left_q <= count_i;
            pop_left_q   <= count_i;
         end else begin
            if (granted) begin
               addr_q       <= addr_q + stride_q;
               issue_left_q <= issue_left_q - 1'b1;
            end
            if (pop) pop_left_q <= pop_left_q - 1'b1;
         end
      end
   end

   hwpe_stream_fifo #(
      .DATA_WIDTH (32),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) i_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .push_valid_i (push),
      .push_data_i  (tcdm_r_data_i),
      .pop_valid_o  (valid_o),
      .pop_data_o   (data_o),
      .pop_ready_i  (ready_i),
      .used_o       (fifo_used)
   );

endmodule

// File: tb/tb_hwpe_stream_source_linear.sv
// tb/tb_hwpe_stream_source_linear.sv - directed bench for the linear source streamer
module tb_hwpe_stream_source_linear;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base = '0;
   logic [31:0] stride = '0;
   logic [15:0] count = '0;
   logic        ready_start, done, tcdm_req, tcdm_wen, valid;
   logic        gnt = 1'b0;
   logic        r_valid = 1'b0;
   logic [31:0] r_data = '0;
   logic [31:0] tcdm_add, tcdm_data, data;
   logic [3:0]  tcdm_be, strb;
   logic        ready = 1'b0;

   hwpe_stream_source_linear #(.FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .clear_i        (clear),
      .start_i        (start),
      .base_addr_i    (base),
      .stride_i       (stride),
      .count_i        (count),
      .ready_start_o  (ready_start),
      .done_o         (done),
      .tcdm_req_o     (tcdm_req),
      .tcdm_gnt_i     (gnt),
      .tcdm_add_o     (tcdm_add),
      .tcdm_wen_o     (tcdm_wen),
      .tcdm_be_o      (tcdm_be),
      .tcdm_data_o    (tcdm_data),
      .tcdm_r_data_i  (r_data),
      .tcdm_r_valid_i (r_valid),
      .valid_o        (valid),
      .data_o         (data),
      .strb_o         (strb),
      .ready_i        (ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd3) ^ 32'h5A5A_0000;
   endfunction

   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   logic [31:0] grant_q[$];
   logic [31:0] pop_q[$];
   int          cyc = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0;
   int          first_gnt_cyc = 0, last_gnt_cyc = 0;
   bit          req_seen = 1'b0, rand_gnt = 1'b0, hold_prev = 1'b0;
   logic [31:0] hold_addr = '0;

   // Sample everything on the falling edge, away from the DUT's active edge
   always @(negedge clk) begin
      cyc++;
      if (hold_prev && tcdm_req) check_eq("addr_hold", tcdm_add, hold_addr);
      hold_prev = tcdm_req && !gnt;
      hold_addr = tcdm_add;
      pend      = tcdm_req && gnt;
      pend_addr = tcdm_add;
      if (tcdm_req) req_seen = 1'b1;
      if (tcdm_req && gnt) begin
         grant_q.push_back(tcdm_add);
         if (grant_q.size() == 1) first_gnt_cyc = cyc;
         last_gnt_cyc = cyc;
      end
      if (valid && ready) begin
         pop_q.push_back(data);
         last_pop_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // Memory: one-cycle response latency after each grant
   always @(posedge clk) begin
      #1;
      r_valid = pend;
      r_data  = pend ? mem_word(pend_addr) : 32'h0;
      if (rand_gnt) gnt = 1'($urandom_range(0, 1));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c);
      base   = b;
      stride = s;
      count  = c;
      start  = 1'b1;
      tick(1);
      start  = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int c0;
      c0 = done_cnt;
      for (int i = 0; i < max && done_cnt == c0; i++) tick(1);
      check_eq("done_seen", 32'(done_cnt > c0), 32'd1);
   endtask

   task automatic check_seq(input string tag, input logic [31:0] b, input logic [31:0] s, input int n);
      logic [31:0] a;
      check_eq({tag, "_gnt_count"}, 32'(grant_q.size()), 32'(n));
      check_eq({tag, "_pop_count"}, 32'(pop_q.size()), 32'(n));
      a = b;
      for (int i = 0; i < n; i++) begin
         check_eq({tag, "_addr"}, (i < grant_q.size()) ? grant_q[i] : 32'hDEAD_BEEF, a);
         check_eq({tag, "_data"}, (i < pop_q.size()) ? pop_q[i] : 32'hDEAD_BEEF, mem_word(a));
         a = a + s;
      end
   endtask

   task automatic clear_logs();
      grant_q.delete();
      pop_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      tick(2);
      check_eq("rst_ready_start", 32'(ready_start), 32'd1);
      check_eq("rst_req", 32'(tcdm_req), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      rst_ni = 1'b1;
      tick(2);

      // Basic transfer at full throughput
      clear_logs();
      gnt   = 1'b1;
      ready = 1'b1;
      c0    = done_cnt;
      do_start(32'h100, 32'd4, 16'd8);
      check_eq("lat_req", 32'(tcdm_req), 32'd1);
      check_eq("lat_addr", tcdm_add, 32'h100);
      check_eq("const_wen", 32'(tcdm_wen), 32'd1);
      check_eq("const_be", 32'(tcdm_be), 32'hF);
      check_eq("const_wdata", tcdm_data, 32'h0);
      check_eq("const_strb", 32'(strb), 32'hF);
      tick(1);
      check_eq("lat_valid_t2", 32'(valid), 32'd0);
      tick(1);
      check_eq("lat_valid_t3", 32'(valid), 32'd1);
      check_eq("lat_data_t3", data, mem_word(32'h100));
      wait_done(40);
      tick(3);
      check_seq("basic", 32'h100, 32'd4, 8);
      check_eq("basic_done_once", 32'(done_cnt - c0), 32'd1);
      check_eq("basic_done_cyc", 32'(done_cyc), 32'(last_pop_cyc + 1));
      check_eq("basic_back_to_back", 32'(last_gnt_cyc - first_gnt_cyc), 32'd7);

      // Backpressure: credits stop requests at FIFO_DEPTH words
      clear_logs();
      ready = 1'b0;
      do_start(32'h1000, 32'd4, 16'd8);
      tick(20);
      check_eq("bp_grants", 32'(grant_q.size()), 32'd4);
      check_eq("bp_req_low", 32'(tcdm_req), 32'd0);
      check_eq("bp_valid", 32'(valid), 32'd1);
      check_eq("bp_head", data, mem_word(32'h1000));
      ready = 1'b1;
      wait_done(60);
      tick(2);
      check_seq("bp", 32'h1000, 32'd4, 8);

      // Random grant with negative stride
      clear_logs();
      rand_gnt = 1'b1;
      do_start(32'h40, 32'hFFFF_FFF8, 16'd5);
      wait_done(200);
      rand_gnt = 1'b0;
      gnt = 1'b1;
      tick(2);
      check_seq("neg", 32'h40, 32'hFFFF_FFF8, 5);

      // Zero-length transfer
      req_seen = 1'b0;
      c0 = done_cnt;
      do_start(32'h80, 32'd4, 16'd0);
      check_eq("zero_done_t1", 32'(done), 32'd1);
      tick(1);
      check_eq("zero_done_t2", 32'(done), 32'd0);
      tick(3);
      check_eq("zero_no_req", 32'(req_seen), 32'd0);
      check_eq("zero_done_once", 32'(done_cnt - c0), 32'd1);
      check_eq("zero_idle", 32'(ready_start), 32'd1);

      // Clear while a response is in flight
      clear_logs();
      ready = 1'b0;
      do_start(32'h300, 32'd4, 16'd8);
      tick(1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check_eq("clr_idle", 32'(ready_start), 32'd1);
      check_eq("clr_req", 32'(tcdm_req), 32'd0);
      check_eq("clr_valid_t1", 32'(valid), 32'd0);
      tick(1);
      check_eq("clr_valid_t2", 32'(valid), 32'd0);
      tick(2);
      check_eq("clr_valid_t4", 32'(valid), 32'd0);
      clear_logs();
      ready = 1'b1;
      do_start(32'h200, 32'd4, 16'd2);
      wait_done(30);
      tick(2);
      check_seq("after_clr", 32'h200, 32'd4, 2);

      // Asynchronous reset in the middle of ISSUE
      gnt = 1'b0;
      do_start(32'h500, 32'd4, 16'd8);
      tick(2);
      check_eq("ar_pre_req", 32'(tcdm_req), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_eq("ar_req", 32'(tcdm_req), 32'd0);
      check_eq("ar_ready_start", 32'(ready_start), 32'd1);
      check_eq("ar_valid", 32'(valid), 32'd0);
      check_eq("ar_done", 32'(done), 32'd0);
      tick(1);
      rst_ni = 1'b1;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
